// File: rtl/cpu_ce_gen.sv
// rtl/cpu_ce_gen.sv - CPU phase clock-enable generator with speed modes, contention stall and switch gap
module cpu_ce_gen #(
  parameter int BASE_DIV   = 16,
  parameter int ALT_DIV    = 27,
  parameter int TURBO_DIV  = 4,
  parameter int AUX_DIV    = 12,
  parameter int SWITCH_GAP = 48
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       wait_en,
  input  logic       wait_req,
  output logic       ce_p,
  output logic       ce_n,
  output logic       ce_aux,
  output logic [1:0] cur_mode,
  output logic       switching
);

  if (BASE_DIV < 2 || ALT_DIV < 2 || TURBO_DIV < 2 || AUX_DIV < 2 || SWITCH_GAP < 1) begin : g_bad_param
    $error("cpu_ce_gen: dividers must be >= 2 and SWITCH_GAP >= 1");
  end

  localparam int MAXD_BA = (BASE_DIV > ALT_DIV) ? BASE_DIV : ALT_DIV;
  localparam int MAXD    = (MAXD_BA > TURBO_DIV) ? MAXD_BA : TURBO_DIV;
  localparam int CW      = $clog2(MAXD);
  localparam int AW      = $clog2(AUX_DIV);
  localparam int GW      = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;

  localparam logic [CW-1:0] BASE_LAST  = CW'(BASE_DIV - 1);
  localparam logic [CW-1:0] ALT_LAST   = CW'(ALT_DIV - 1);
  localparam logic [CW-1:0] TURBO_LAST = CW'(TURBO_DIV - 1);
  localparam logic [CW-1:0] BASE_HALF  = CW'(BASE_DIV / 2);
  localparam logic [CW-1:0] ALT_HALF   = CW'(ALT_DIV / 2);
  localparam logic [CW-1:0] TURBO_HALF = CW'(TURBO_DIV / 2);
  localparam logic [AW-1:0] AUX_LAST   = AW'(AUX_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(SWITCH_GAP - 1);

  typedef enum logic {RUN, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] aux_q, aux_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    mode_q, mode_d;
  logic          gate_q, gate_d;
  logic          ce_p_q, ce_p_d;
  logic          ce_n_q, ce_n_d;
  logic          ce_aux_q, ce_aux_d;

  logic [1:0]    eff_mode;
  logic [CW-1:0] last_cnt;
  logic [CW-1:0] half_cnt;

  always_comb begin
    eff_mode = (mode == 2'b11) ? 2'b00 : mode;
    case (mode_q)
      2'b01:   begin last_cnt = ALT_LAST;   half_cnt = ALT_HALF;   end
      2'b10:   begin last_cnt = TURBO_LAST; half_cnt = TURBO_HALF; end
      default: begin last_cnt = BASE_LAST;  half_cnt = BASE_HALF;  end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    gate_d   = gate_q;
    ce_p_d   = 1'b0;
    ce_n_d   = 1'b0;
    ce_aux_d = (aux_q == '0);
    aux_d    = (aux_q == AUX_LAST) ? '0 : aux_q + AW'(1);

    case (state_q)
      RUN: begin
        ce_p_d = gate_q && (cnt_q == '0);
        ce_n_d = gate_q && (cnt_q == half_cnt);
        if (cnt_q == last_cnt) begin
          // The gate decided here covers the whole following period; cnt keeps running.
          cnt_d  = '0;
          gate_d = (mode_q == 2'b00) ? ~(wait_en & wait_req) : 1'b1;
          if (eff_mode != mode_q) begin
            state_d = GAP;
            gap_d   = GAP_LAST;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          mode_d  = eff_mode;
          cnt_d   = '0;
          gate_d  = 1'b1;
          state_d = RUN;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      aux_q    <= '0;
      gap_q    <= '0;
      mode_q   <= 2'b00;
      gate_q   <= 1'b1;
      ce_p_q   <= 1'b0;
      ce_n_q   <= 1'b0;
      ce_aux_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      aux_q    <= aux_d;
      gap_q    <= gap_d;
      mode_q   <= mode_d;
      gate_q   <= gate_d;
      ce_p_q   <= ce_p_d;
      ce_n_q   <= ce_n_d;
      ce_aux_q <= ce_aux_d;
    end
  end

  assign ce_p      = ce_p_q;
  assign ce_n      = ce_n_q;
  assign ce_aux    = ce_aux_q;
  assign cur_mode  = mode_q;
  assign switching = (state_q == GAP);

endmodule

// File: doc/cpu_ce_gen.md
CPU_CE_GEN -- requirements
Module: cpu_ce_gen

Interface
REQ-001 SHALL have parameter BASE_DIV, default 16: clk_sys cycles per CPU period in mode 0 (native).
REQ-002 SHALL have parameter ALT_DIV, default 27: cycles per period in mode 1 (alternate machine speed).
REQ-003 SHALL have parameter TURBO_DIV, default 4: cycles per period in mode 2 (turbo).
REQ-004 SHALL have parameter AUX_DIV, default 12: period of the free-running auxiliary (sound) enable.
REQ-005 SHALL have parameter SWITCH_GAP, default 48: dead cycles inserted on a mode change.
REQ-006 SHALL reject at elaboration any divider below 2 or SWITCH_GAP below 1.
REQ-007 clk_sys  in  1  system clock; the only clock.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 mode  in  2  requested speed: 00 native, 01 alt, 10 turbo, 11 treated as 00.
REQ-010 wait_en  in  1  contention enable; honoured only in mode 0.
REQ-011 wait_req  in  1  contention request (memory/IO wait), level.
REQ-012 ce_p  out  1  CPU positive-phase enable, one-cycle pulse.
REQ-013 ce_n  out  1  CPU negative-phase enable, one-cycle pulse.
REQ-014 ce_aux  out  1  auxiliary enable, one-cycle pulse every AUX_DIV cycles.
REQ-015 cur_mode  out  2  mode currently in effect (never 11).
REQ-016 switching  out  1  high while a mode change is in progress.

Function
REQ-017 SHALL keep a period counter cnt, width clog2 of the largest divider, counting 0..DIV-1 of cur_mode and wrapping to 0.
REQ-018 SHALL register ce_p high in the cycle after a cycle with cnt==0, gate==1 and state RUN; ce_n likewise for cnt==DIV/2 (floor). No combinational path from any input to any output.
REQ-019 SHALL never assert ce_p and ce_n in the same cycle.
REQ-020 SHALL update gate at cnt==DIV-1: gate <= ~(wait_en & wait_req) in mode 0, else 1; gate holds for the whole next period, suppressing both of its pulses.
REQ-021 SHALL NOT stop cnt when gate==0; a stalled period costs exactly DIV cycles.
REQ-022 SHALL have states RUN and GAP; in RUN, if the effective mode differs from cur_mode at cnt==DIV-1, go to GAP with gap counter = SWITCH_GAP-1.
REQ-023 In GAP SHALL emit no ce_p/ce_n, hold switching high, decrement the gap counter each cycle.
REQ-024 At gap counter 0 SHALL load cur_mode from the effective mode sampled that cycle, set cnt=0, gate=1, return to RUN.
REQ-025 A mode reverting during GAP SHALL still complete the gap; if the reloaded mode equals the old one, cur_mode is unchanged.
REQ-026 Mode changes outside cnt==DIV-1 SHALL take effect only at the next period end; a request pulse shorter than the remaining period is ignored.
REQ-027 ce_aux SHALL run from an independent counter modulo AUX_DIV, unaffected by mode, gate or GAP.
REQ-028 Spacing between consecutive ce_p in RUN SHALL be exactly DIV of cur_mode; across a switch it SHALL be at least old DIV + SWITCH_GAP.

Reset
REQ-029 When rst_n is low at a clk_sys edge: cnt=0, aux counter=0, state RUN, cur_mode=00, gate=1, gap counter=0; ce_p, ce_n, ce_aux, switching = 0.
REQ-030 Reset asserted during GAP SHALL abort the switch; after release, mode 00 runs regardless of mode input until the first period end.
REQ-031 After rst_n rises, first ce_p SHALL appear exactly 1 cycle later, first ce_aux 1 cycle later.

Verification
REQ-032 Defaults, mode=00, wait_en=0: ce_p every 16 cycles, ce_n 8 cycles after each ce_p, ce_aux every 12 cycles.
REQ-033 Mode 00, wait_en=1, wait_req held high across one period end: that period's ce_p and ce_n absent, next period normal, ce_p gap 32 cycles.
REQ-034 Switch 00->01 mid-period: switching high 48 cycles from period end, then ce_p every 27 cycles, ce_n 13 after ce_p, cur_mode=01.
REQ-035 mode=11 from reset: behaves as 00, cur_mode stays 00, no GAP entered.
REQ-036 Request 10 then revert to 00 during GAP: GAP completes 48 cycles, cur_mode returns 00, period 16; ce_aux cadence unbroken throughout.
REQ-037 rst_n low 3 cycles inside GAP in turbo switch: switching drops next cycle, cur_mode=00, ce_p 1 cycle after release.
